// File: rtl/timer_tens_minutes_ctrl_if.sv
// timer_tens_minutes_ctrl_if
//   Groups the command, preset, units-digit status and result signals of the
//   tens/minutes countdown controller.
//   master : drives start/pause/load, presets and the units-digit flags,
//            observes the digits and status outputs.
//   slave  : the controller itself.
//   Signals:
//     start, pause, load        one-cycle commands (synchronous to clk1)
//     preset_tens, preset_min   4-bit BCD presets captured on load
//     borrow_in, units_zero     units-digit flags, asynchronous to clk1
//     q_tens, q_min             current BCD digits
//     units_hold                freezes the units counter while high
//     done                      one-cycle pulse on reaching 0:00
//     state                     IDLE=00, RUN=01, PAUSE=10, DONE=11
//     reload_req                one-cycle units-counter reload request
interface timer_tens_minutes_ctrl_if;
    logic       start;
    logic       pause;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_min;
    logic       borrow_in;
    logic       units_zero;
    logic [3:0] q_tens;
    logic [3:0] q_min;
    logic       units_hold;
    logic       done;
    logic [1:0] state;
    logic       reload_req;

    modport master (
        output start, pause, load, preset_tens, preset_min, borrow_in, units_zero,
        input  q_tens, q_min, units_hold, done, state, reload_req
    );

    modport slave (
        input  start, pause, load, preset_tens, preset_min, borrow_in, units_zero,
        output q_tens, q_min, units_hold, done, state, reload_req
    );
endinterface

// File: rtl/timer_tens_minutes_ctrl.sv
// timer_tens_minutes_ctrl
//   Controls the tens-of-seconds and minutes digits of an M:SS countdown
//   timer. The units digit lives elsewhere; it reports its borrow (high
//   while the units digit is 9) and zero status asynchronously, and this
//   block counts the upper digits down on each synchronized borrow edge.
//   Ports:
//     clk1   rising-edge system clock
//     reset  asynchronous active-low reset
//     bus    timer_tens_minutes_ctrl_if.slave (commands, presets, flags,
//            digits and status; see the interface header)
//   Parameters:
//     TENS_MAX  highest tens-of-seconds value (default 5)
//     MIN_MAX   highest minutes value (default 9)
//   Configuration macro:
//     AUTO_RELOAD_EN  when defined, DONE lasts one cycle and is followed by
//                     a reload of the stored presets, a reload_req pulse and
//                     a return to RUN. When undefined, DONE is held until a
//                     load and reload_req stays 0.
module timer_tens_minutes_ctrl #(
    parameter int TENS_MAX = 5,
    parameter int MIN_MAX  = 9
) (
    input  logic                          clk1,
    input  logic                          reset,
    timer_tens_minutes_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] TENS_MAX_C = 4'(TENS_MAX);
    localparam logic [3:0] MIN_MAX_C  = 4'(MIN_MAX);

    // Saturate a preset digit to its legal upper bound.
    function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                               input logic [3:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    // Two-stage synchronizers plus the previous-borrow register for edge detect.
    logic borrow_meta_q, borrow_sync_q, borrow_prev_q;
    logic uz_meta_q, uz_sync_q;

    state_t     state_q,       state_d;
    logic [3:0] tens_q,        tens_d;
    logic [3:0] min_q,         min_d;
    logic [3:0] preset_tens_q, preset_tens_d;
    logic [3:0] preset_min_q,  preset_min_d;
    logic       done_q,        done_d;
    logic       reload_req_q,  reload_req_d;
    logic       units_hold_q,  units_hold_d;

    logic borrow_event_s;
    logic at_zero_s;

    // Bring the asynchronous units-digit flags into the clk1 domain.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            borrow_meta_q <= 1'b0;
            borrow_sync_q <= 1'b0;
            borrow_prev_q <= 1'b0;
            uz_meta_q     <= 1'b0;
            uz_sync_q     <= 1'b0;
        end else begin
            borrow_meta_q <= bus.borrow_in;
            borrow_sync_q <= borrow_meta_q;
            borrow_prev_q <= borrow_sync_q;
            uz_meta_q     <= bus.units_zero;
            uz_sync_q     <= uz_meta_q;
        end
    end

    // Next-state, digit and output logic for the countdown FSM.
    always_comb begin
        borrow_event_s = borrow_sync_q & ~borrow_prev_q;
        at_zero_s      = (tens_q == 4'd0) && (min_q == 4'd0);

        state_d       = state_q;
        tens_d        = tens_q;
        min_d         = min_q;
        preset_tens_d = preset_tens_q;
        preset_min_d  = preset_min_q;
        done_d        = 1'b0;
        reload_req_d  = 1'b0;

        if (bus.load) begin
            state_d       = ST_IDLE;
            tens_d        = clamp_digit(bus.preset_tens, TENS_MAX_C);
            min_d         = clamp_digit(bus.preset_min, MIN_MAX_C);
            preset_tens_d = clamp_digit(bus.preset_tens, TENS_MAX_C);
            preset_min_d  = clamp_digit(bus.preset_min, MIN_MAX_C);
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (bus.start) begin
                        // Starting at 0:00 with the units digit already zero finishes at once.
                        if (at_zero_s && uz_sync_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    // A borrow is applied even when pause arrives in the same cycle.
                    if (borrow_event_s && !at_zero_s) begin
                        if (tens_q != 4'd0) begin
                            tens_d = tens_q - 4'd1;
                        end else begin
                            tens_d = TENS_MAX_C;
                            min_d  = min_q - 4'd1;
                        end
                    end else begin
                        tens_d = tens_q;
                    end
                    // Completion wins over a simultaneous pause so the done pulse is never lost.
                    if (at_zero_s && uz_sync_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef AUTO_RELOAD_EN
                    state_d      = ST_RUN;
                    tens_d       = preset_tens_q;
                    min_d        = preset_min_q;
                    reload_req_d = 1'b1;
`else
                    state_d      = ST_DONE;
                    reload_req_d = 1'b0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        units_hold_d = (state_d != ST_RUN);
    end

    // Countdown state, digits, stored presets and registered outputs.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tens_q        <= 4'd0;
            min_q         <= 4'd0;
            preset_tens_q <= 4'd0;
            preset_min_q  <= 4'd0;
            done_q        <= 1'b0;
            reload_req_q  <= 1'b0;
            units_hold_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            min_q         <= min_d;
            preset_tens_q <= preset_tens_d;
            preset_min_q  <= preset_min_d;
            done_q        <= done_d;
            reload_req_q  <= reload_req_d;
            units_hold_q  <= units_hold_d;
        end
    end

    assign bus.q_tens     = tens_q;
    assign bus.q_min      = min_q;
    assign bus.state      = state_q;
    assign bus.units_hold = units_hold_q;
    assign bus.done       = done_q;
    assign bus.reload_req = reload_req_q;

endmodule

// File: doc/timer_tens_minutes_ctrl.md
TIMER_TENS_MINUTES_CTRL -- requirements
Module: timer_tens_minutes_ctrl

Interface
REQ-001 The block SHALL have parameter TENS_MAX, default 5, meaning the highest tens-of-seconds value.
REQ-002 The block SHALL have parameter MIN_MAX, default 9, meaning the highest minutes value.
REQ-003 Port clk1  in  1  system clock; all registers update on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  synchronous one-cycle request to run or resume.
REQ-006 Port pause  in  1  synchronous one-cycle request to pause.
REQ-007 Port load  in  1  synchronous one-cycle request to load the presets.
REQ-008 Port preset_tens  in  4  tens-of-seconds preset value.
REQ-009 Port preset_min  in  4  minutes preset value.
REQ-010 Port borrow_in  in  1  units-digit borrow flag, high while the units digit is 9; asynchronous to clk1.
REQ-011 Port units_zero  in  1  units-digit-is-zero flag; asynchronous to clk1.
REQ-012 Port q_tens  out  4  current tens-of-seconds digit, binary-coded decimal (BCD).
REQ-013 Port q_min  out  4  current minutes digit, BCD.
REQ-014 Port units_hold  out  1  freezes the units counter while high.
REQ-015 Port done  out  1  one-cycle pulse when the countdown reaches 0:00.
REQ-016 Port state  out  2  FSM state encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-017 Port reload_req  out  1  one-cycle request for the units counter to reload; tied to 0 unless AUTO_RELOAD_EN is defined.

Function
REQ-018 borrow_in and units_zero SHALL each pass through a 2-flip-flop synchronizer before use.
REQ-019 A borrow event SHALL be a synchronized 0->1 edge of borrow_in; each event is counted once, and the count updates on the clk1 edge that follows detection.
REQ-020 Command priority SHALL be load > start > pause when several are high in the same cycle.
REQ-021 load, in any state, SHALL go to IDLE, clamp the presets (tens above TENS_MAX -> TENS_MAX; minutes above MIN_MAX -> MIN_MAX), write the clamped values to q_tens/q_min and to the stored-preset registers.
REQ-022 start in IDLE or PAUSE SHALL go to RUN; start in RUN or DONE SHALL be ignored.
REQ-023 start when q_tens=0, q_min=0 and synchronized units_zero=1 SHALL go directly to DONE and pulse done.
REQ-024 pause in RUN SHALL go to PAUSE; pause in any other state SHALL be ignored.
REQ-025 A borrow event in RUN SHALL act as follows:
- q_tens>0: decrement q_tens.
- q_tens=0 and q_min>0: set q_tens=TENS_MAX and decrement q_min.
REQ-026 A borrow event at q_tens=0, q_min=0, or in a state other than RUN, SHALL be ignored (no underflow).
REQ-027 A borrow event coinciding with pause in RUN SHALL still be applied, and the FSM then enters PAUSE.
REQ-028 RUN SHALL go to DONE in the cycle where q_tens=0, q_min=0 and synchronized units_zero=1, with done high for exactly that transition cycle.
REQ-029 units_hold SHALL be 1 in IDLE, PAUSE and DONE, and 0 in RUN.
REQ-030 DONE SHALL be left only by load or by auto-reload (REQ-034).
REQ-031 q_tens and q_min SHALL always hold legal BCD values within 0..TENS_MAX and 0..MIN_MAX.

Reset
REQ-032 While reset=0, the block SHALL force: q_tens=0, q_min=0, stored presets=0, state=IDLE, units_hold=1, done=0, reload_req=0, and synchronizer/edge registers=0.
REQ-033 Reset asserted mid-RUN SHALL take effect immediately (asynchronously); after release the block stays in IDLE until load or start.

Configuration
REQ-034 With macro AUTO_RELOAD_EN defined, DONE SHALL last one cycle, and in the next cycle the block SHALL:
- restore q_tens/q_min from the stored presets;
- pulse reload_req for one cycle;
- enter RUN.
REQ-035 Without AUTO_RELOAD_EN, the block SHALL remain in DONE, with reload_req held at 0.

Verification
REQ-036 Load tens=3, min=2; start; 1 borrow -> q_tens=2, q_min=2, state=RUN, units_hold=0.
REQ-037 Load tens=0, min=1; start; 1 borrow -> q_tens=5, q_min=0; then units_zero=1 with no further borrow stays RUN; after 5 more borrows and units_zero=1 -> done pulses once, state=DONE, units_hold=1.
REQ-038 Load tens=9, min=12 -> q_tens=5, q_min=9 (clamped).
REQ-039 RUN with pause and a borrow edge in the same cycle -> borrow counted, state=PAUSE; further borrows ignored; start -> RUN.
REQ-040 Assert reset mid-RUN at 3:4x -> all outputs take their reset values immediately; with AUTO_RELOAD_EN, reaching 0:00 after load 1:0 -> done, then reload_req pulses, q_tens=0, q_min=1, state=RUN.
